pll_lock_supervisor: RTL and testbench



---
 rtl/pll_sup_pkg.sv | 22 ++
 rtl/sync2.sv | 21 ++
 rtl/pll_lock_supervisor.sv | 110 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    PLLRST = 2'd0,
    WAIT   = 2'd1,
    STABLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam int LOSS_CNT_W = 8;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset pulser, lock qualifier and core reset / ready sequencer.
//
// state  | meaning
// PLLRST | pll_rst asserted for PLL_RST_LEN cycles
// WAIT   | waiting for synchronized lock, re-pulse PLL on timeout
// STABLE | lock must hold LOCK_STABLE cycles before core release
// RUN    | core out of reset, ready after READY_DLY cycles
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_LEN  = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 1024,
  parameter int READY_DLY    = 5000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  locked,
  input  logic                  btn_rst,
  output logic                  pll_rst,
  output logic                  rst_core_n,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [1:0]            state
);

  localparam int CNT_W = $clog2(max4(PLL_RST_LEN, LOCK_TIMEOUT, LOCK_STABLE, READY_DLY)) + 1;

  localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(PLL_RST_LEN - 1);
  localparam logic [CNT_W-1:0] TMO_TC    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] READY_TC  = CNT_W'(READY_DLY);

  logic                  locked_s;
  logic                  btn_s;
  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [LOSS_CNT_W-1:0] loss_d;

  sync2 u_sync_locked (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  sync2 u_sync_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_rst),
    .q     (btn_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    loss_d  = lock_loss_cnt;
    case (state_q)
      PLLRST: begin
        if (cnt_q == RST_TC) state_d = WAIT;
      end
      WAIT: begin
        if (locked_s)              state_d = STABLE;
        else if (cnt_q == TMO_TC)  state_d = PLLRST;
      end
      STABLE: begin
        if (!locked_s)               state_d = WAIT;
        else if (cnt_q == STABLE_TC) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == READY_TC) cnt_d = cnt_q;
        if (!locked_s) begin
          state_d = WAIT;
          if (lock_loss_cnt != '1) loss_d = lock_loss_cnt + LOSS_CNT_W'(1);
        end
      end
      default: state_d = PLLRST;
    endcase
    // Button overrides everything and holds the PLL pulse counter at zero.
    if (btn_s) begin
      state_d = PLLRST;
      loss_d  = lock_loss_cnt;
    end
    if (btn_s || (state_d != state_q)) cnt_d = '0;
  end

  // Outputs are registered from the next-state values so they switch with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= PLLRST;
      cnt_q         <= '0;
      pll_rst       <= 1'b1;
      rst_core_n    <= 1'b0;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pll_rst       <= (state_d == PLLRST);
      rst_core_n    <= (state_d == RUN);
      ready         <= (state_d == RUN) && (cnt_d == READY_TC);
      lock_loss_cnt <= loss_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters.
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic       btn_rst = 1'b0;
  logic       pll_rst;
  logic       rst_core_n;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  logic [1:0] state;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int k;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .PLL_RST_LEN  (4),
    .LOCK_TIMEOUT (32),
    .LOCK_STABLE  (8),
    .READY_DLY    (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .locked        (locked),
    .btn_rst       (btn_rst),
    .pll_rst       (pll_rst),
    .rst_core_n    (rst_core_n),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt),
    .state         (state)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic wait_core(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (rst_core_n !== lvl && n < budget) begin
      tick();
      n++;
    end
    chk(tag, int'(rst_core_n), int'(lvl));
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    chk(tag, int'(state), int'(s));
  endtask

  initial begin
    // reset values
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_core_n", rst_core_n, 0);
    chk("rst_ready", ready, 0);
    chk("rst_loss", lock_loss_cnt, 0);
    rst_n = 1'b1;
    cyc = 0;

    // no lock: 4 high / 32 low, repeating
    for (int c = 0; c < 80; c++) begin
      tick_to(c);
      chk("t1_pll_rst", pll_rst, ((c % 36) < 4) ? 1 : 0);
      chk("t1_state", state, ((c % 36) < 4) ? 0 : 1);
      chk("t1_core", rst_core_n, 0);
    end

    // clean lock at cycle 10
    do_reset();
    tick_to(10);
    locked = 1'b1;
    tick_to(12); chk("t2_wait", state, 1);
    tick_to(13); chk("t2_stable", state, 2);
    tick_to(20); chk("t2_core_pre", rst_core_n, 0);
    tick_to(21); chk("t2_core", rst_core_n, 1);
                 chk("t2_run", state, 3);
    tick_to(36); chk("t2_ready_pre", ready, 0);
    tick_to(37); chk("t2_ready", ready, 1);

    // lock glitch in STABLE at count 5
    locked = 1'b0;
    do_reset();
    tick_to(10);
    locked = 1'b1;
    tick_to(16);
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick_to(18); chk("t3_stable", state, 2);
    tick_to(19); chk("t3_back_wait", state, 1);
    tick_to(20); chk("t3_restable", state, 2);
    tick_to(27); chk("t3_core_pre", rst_core_n, 0);
    tick_to(28); chk("t3_core", rst_core_n, 1);

    // lock loss in RUN
    tick_to(50);
    chk("t4_ready", ready, 1);
    chk("t4_loss0", lock_loss_cnt, 0);
    locked = 1'b0;
    tick_to(52); chk("t4_core_hold", rst_core_n, 1);
    tick_to(53);
    chk("t4_core", rst_core_n, 0);
    chk("t4_ready_drop", ready, 0);
    chk("t4_state", state, 1);
    chk("t4_loss1", lock_loss_cnt, 1);

    // one-cycle button in RUN
    locked = 1'b1;
    wait_core(1'b1, 40, "t5_relock");
    repeat (3) tick();
    btn_rst = 1'b1;
    k = cyc;
    tick();
    btn_rst = 1'b0;
    tick_to(k + 2);  chk("t5_pll_pre", pll_rst, 0);
                     chk("t5_core_pre", rst_core_n, 1);
    tick_to(k + 3);  chk("t5_pll_on", pll_rst, 1);
                     chk("t5_core_off", rst_core_n, 0);
                     chk("t5_state", state, 0);
    tick_to(k + 6);  chk("t5_pll_last", pll_rst, 1);
    tick_to(k + 7);  chk("t5_pll_off", pll_rst, 0);
                     chk("t5_wait", state, 1);
    tick_to(k + 8);  chk("t5_stable", state, 2);
    tick_to(k + 15); chk("t5_core_pre2", rst_core_n, 0);
    tick_to(k + 16); chk("t5_core_on", rst_core_n, 1);
                     chk("t5_loss", lock_loss_cnt, 1);

    // held button restarts the pulse until released
    btn_rst = 1'b1;
    k = cyc;
    tick_to(k + 10);
    btn_rst = 1'b0;
    tick_to(k + 15); chk("t5h_pll_hold", pll_rst, 1);
    tick_to(k + 16); chk("t5h_pll_off", pll_rst, 0);
                     chk("t5h_loss", lock_loss_cnt, 1);

    // 300 more losses saturate the counter
    wait_core(1'b1, 40, "t4s_first_run");
    for (int i = 0; i < 300; i++) begin
      locked = 1'b0;
      wait_core(1'b0, 6, "t4s_drop");
      locked = 1'b1;
      wait_core(1'b1, 20, "t4s_relock");
    end
    chk("t4s_loss_sat", lock_loss_cnt, 255);

    // reset pulse during STABLE
    locked = 1'b0;
    wait_state(2'd1, 6, "t6_wait");
    locked = 1'b1;
    wait_state(2'd2, 6, "t6_stable");
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_state", state, 0);
    chk("t6_pll_rst", pll_rst, 1);
    chk("t6_core", rst_core_n, 0);
    chk("t6_ready", ready, 0);
    chk("t6_loss", lock_loss_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
